// File: rtl/icap_pkg.sv
// Shared constants, FSM state type and byte bit-reversal helper for the ICAP write sequencer.
package icap_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [DATA_W-1:0] SYNC_WORD  = 32'hAA99_5566;
    localparam logic [DATA_W-1:0] CMD_HDR    = 32'h3000_8001;
    localparam logic [DATA_W-1:0] DESYNC_CMD = 32'h0000_000D;
    localparam logic [DATA_W-1:0] NOOP_WORD  = 32'h2000_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HUNT,
        ST_SYNCED,
        ST_ABORT_HDR,
        ST_ABORT_CMD,
        ST_PAD,
        ST_DONE
    } icap_state_e;

    // Reverse bit order inside each byte (7-series ICAP ordering for raw .bin data).
    function automatic logic [DATA_W-1:0] bitswap32(input logic [DATA_W-1:0] w);
        logic [DATA_W-1:0] r;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 8; i++) begin
                r[8*b + i] = w[8*b + 7 - i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/icap_write_ctrl.sv
// Write-side sequencer feeding ICAPE2: tracks sync/desync, forwards words, appends a desync trailer on stall.
// Define ICAP_BITSWAP_EN to bit-reverse each byte of icap_i.
module icap_write_ctrl
    import icap_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned NOOP_PAD       = 4,
    parameter int unsigned TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [31:0] icap_i,
    output logic        icap_csib,
    output logic        icap_rdwrb,
    output logic        busy,
    output logic        synced,
    output logic        done,
    output logic        err,
    output logic [31:0] word_cnt
);

    localparam int unsigned PAD_W = (NOOP_PAD > 1) ? $clog2(NOOP_PAD) : 1;

    icap_state_e       state, state_nxt;
    logic [DATA_W-1:0] hist, hist_nxt;
    logic [TO_W-1:0]   to_cnt, to_cnt_nxt;
    logic [PAD_W-1:0]  pad_cnt, pad_cnt_nxt;
    logic              err_nxt;
    logic              done_nxt;
    logic              out_vld;
    logic [DATA_W-1:0] out_word;
    logic [DATA_W-1:0] icap_word_c;
    logic              accept;
    icap_state_e       pad_entry;

    assign accept    = s_valid && s_ready;
    // With no padding configured the trailer skips PAD entirely.
    assign pad_entry = (NOOP_PAD == 0) ? ST_DONE : ST_PAD;

`ifdef ICAP_BITSWAP_EN
    assign icap_word_c = bitswap32(out_word);
`else
    assign icap_word_c = out_word;
`endif

    // Next-state, emitted word and bookkeeping.
    always_comb begin
        state_nxt   = state;
        hist_nxt    = hist;
        to_cnt_nxt  = '0;
        pad_cnt_nxt = pad_cnt;
        err_nxt     = err;
        done_nxt    = 1'b0;
        out_vld     = 1'b0;
        out_word    = '0;

        case (state)
            ST_IDLE, ST_HUNT: begin
                if (accept) begin
                    out_vld  = 1'b1;
                    out_word = s_data;
                    if (s_data == SYNC_WORD) begin
                        state_nxt = ST_SYNCED;
                    end else begin
                        state_nxt = ST_HUNT;
                    end
                end
            end
            ST_SYNCED: begin
                if (accept) begin
                    out_vld  = 1'b1;
                    out_word = s_data;
                    hist_nxt = s_data;
                    if (hist == CMD_HDR && s_data == DESYNC_CMD) begin
                        state_nxt = pad_entry;
                    end
                end else begin
                    // An accept in the expiry cycle takes the branch above, so it always wins.
                    to_cnt_nxt = to_cnt + 1'b1;
                    if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        err_nxt   = 1'b1;
                        state_nxt = ST_ABORT_HDR;
                    end
                end
            end
            ST_ABORT_HDR: begin
                out_vld   = 1'b1;
                out_word  = CMD_HDR;
                state_nxt = ST_ABORT_CMD;
            end
            ST_ABORT_CMD: begin
                out_vld   = 1'b1;
                out_word  = DESYNC_CMD;
                state_nxt = pad_entry;
            end
            ST_PAD: begin
                out_vld  = 1'b1;
                out_word = NOOP_WORD;
                if (32'(pad_cnt) + 32'd1 >= NOOP_PAD) begin
                    pad_cnt_nxt = '0;
                    state_nxt   = ST_DONE;
                end else begin
                    pad_cnt_nxt = pad_cnt + 1'b1;
                end
            end
            ST_DONE: begin
                done_nxt  = 1'b1;
                hist_nxt  = '0;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            hist       <= '0;
            to_cnt     <= '0;
            pad_cnt    <= '0;
            err        <= 1'b0;
            done       <= 1'b0;
            icap_i     <= '0;
            icap_csib  <= 1'b1;
            icap_rdwrb <= 1'b0;
            s_ready    <= 1'b1;
            busy       <= 1'b0;
            synced     <= 1'b0;
            word_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            hist       <= hist_nxt;
            to_cnt     <= to_cnt_nxt;
            pad_cnt    <= pad_cnt_nxt;
            err        <= err_nxt;
            done       <= done_nxt;
            icap_csib  <= !out_vld;
            icap_rdwrb <= 1'b0;
            s_ready    <= (state_nxt == ST_IDLE) || (state_nxt == ST_HUNT) || (state_nxt == ST_SYNCED);
            busy       <= (state_nxt != ST_IDLE);
            synced     <= (state_nxt == ST_SYNCED);
            if (out_vld) begin
                icap_i <= icap_word_c;
            end
            if (out_vld && word_cnt != '1) begin
                word_cnt <= word_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_icap_write_ctrl.sv
// Randomized scoreboard bench for icap_write_ctrl against a packet-level reference model.
`timescale 1ns/1ps
module tb_icap_write_ctrl;

    localparam int unsigned T  = 1024;
    localparam int unsigned NP = 4;
    localparam logic [31:0] SYNC = 32'hAA995566;
    localparam logic [31:0] HDR  = 32'h30008001;
    localparam logic [31:0] DSY  = 32'h0000000D;
    localparam logic [31:0] NOOP = 32'h20000000;
    localparam logic [32:0] DONE_MARK = {1'b1, 32'h0};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] icap_i;
    logic        icap_csib;
    logic        icap_rdwrb;
    logic        busy;
    logic        synced;
    logic        done;
    logic        err;
    logic [31:0] word_cnt;

    always #5 clk = ~clk;

    icap_write_ctrl #(.TIMEOUT_CYCLES(T), .NOOP_PAD(NP)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .icap_i(icap_i), .icap_csib(icap_csib), .icap_rdwrb(icap_rdwrb), .busy(busy),
        .synced(synced), .done(done), .err(err), .word_cnt(word_cnt)
    );

    int total = 0;
    int bad = 0;
    int done_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_swap(input logic [31:0] w);
        logic [31:0] r;
        r = w;
`ifdef ICAP_BITSWAP_EN
        for (int i = 0; i < 32; i++) r[(i & ~7) + (7 - (i & 7))] = w[i];
`endif
        return r;
    endfunction

    // Reference model: packet-level view of the stream plus a queue of trailer actions.
    logic [31:0] exp_q[$];
    logic [32:0] trail[$];
    bit          m_active, m_sync;
    logic [31:0] m_prev;
    int          m_gap;
    logic        e_csib, e_ready, e_busy, e_synced, e_done, e_err;
    logic [31:0] e_wc;

    task automatic model_reset();
        exp_q.delete();
        trail.delete();
        m_active = 0; m_sync = 0; m_prev = '0; m_gap = 0;
        e_csib = 1; e_ready = 1; e_busy = 0; e_synced = 0; e_done = 0; e_err = 0; e_wc = '0;
    endtask

    task automatic emit(input logic [31:0] w);
        exp_q.push_back(ref_swap(w));
        e_csib = 0;
        if (e_wc != 32'hFFFFFFFF) e_wc = e_wc + 1;
    endtask

    task automatic push_pad();
        for (int i = 0; i < NP; i++) trail.push_back({1'b0, NOOP});
        trail.push_back(DONE_MARK);
    endtask

    always @(posedge clk or negedge rst) begin
        logic        acc;
        logic [32:0] t;
        if (!rst) begin
            model_reset();
        end else begin
            acc = s_valid && e_ready;
            e_csib = 1;
            e_done = 0;
            if (trail.size() > 0) begin
                t = trail.pop_front();
                if (t[32]) begin
                    e_done = 1;
                    m_active = 0;
                end else begin
                    emit(t[31:0]);
                end
            end else if (acc) begin
                emit(s_data);
                m_active = 1;
                if (m_sync) begin
                    m_gap = 0;
                    if (m_prev == HDR && s_data == DSY) begin
                        m_sync = 0;
                        push_pad();
                    end
                    m_prev = s_data;
                end else if (s_data == SYNC) begin
                    m_sync = 1; m_prev = '0; m_gap = 0;
                end
            end else if (m_sync) begin
                m_gap++;
                if (m_gap == T) begin
                    e_err = 1;
                    m_sync = 0;
                    trail.push_back({1'b0, HDR});
                    trail.push_back({1'b0, DSY});
                    push_pad();
                end
            end
            e_ready = (trail.size() == 0);
            e_synced = m_sync;
            e_busy = m_active;
        end
    end

    // Monitor: compare DUT outputs against the model on the falling edge.
    always @(negedge clk) begin
        logic [31:0] w;
        if (rst) begin
            check("csib", 32'(icap_csib), 32'(e_csib));
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                if (!icap_csib) check("icap_i", icap_i, w);
            end
            if (done) done_seen++;
            check("s_ready", 32'(s_ready), 32'(e_ready));
            check("busy", 32'(busy), 32'(e_busy));
            check("synced", 32'(synced), 32'(e_synced));
            check("done", 32'(done), 32'(e_done));
            check("err", 32'(err), 32'(e_err));
            check("rdwrb", 32'(icap_rdwrb), 32'(1'b0));
            check("word_cnt", word_cnt, e_wc);
        end
    end

    task automatic cyc(input logic v, input logic [31:0] d);
        @(negedge clk);
        s_valid = v;
        s_data  = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'h0);
    endtask

    initial begin
        int d0;
        logic [31:0] seq1 [7];
        logic [31:0] last;
        seq1 = '{32'hFFFFFFFF, 32'h000000BB, 32'h11220044, SYNC, NOOP, HDR, DSY};
        model_reset();

        #12;
        check("rst csib", 32'(icap_csib), 32'd1);
        check("rst icap_i", icap_i, 32'd0);
        check("rst word_cnt", word_cnt, 32'd0);
        check("rst busy/synced/done/err", {28'd0, busy, synced, done, err}, 32'd0);
        @(negedge clk); #2 rst = 1'b1;

        // Directed sync/desync stream.
        d0 = done_seen;
        foreach (seq1[i]) cyc(1'b1, seq1[i]);
        idle(10);
        check("seq1 word_cnt", word_cnt, 32'd11);
        check("seq1 done pulses", 32'(done_seen - d0), 32'd1);
        check("seq1 idle", 32'(busy), 32'd0);

        // Stall after sync until the timeout trailer runs.
        d0 = done_seen;
        cyc(1'b1, SYNC);
        idle(T + 12);
        check("timeout err", 32'(err), 32'd1);
        check("timeout word_cnt", word_cnt, 32'd18);
        check("timeout done pulses", 32'(done_seen - d0), 32'd1);

        // Asynchronous reset mid-packet.
        cyc(1'b1, SYNC);
        for (int i = 0; i < 5; i++) cyc(1'b1, $urandom);
        #2 rst = 1'b0;
        #1;
        check("midrst csib", 32'(icap_csib), 32'd1);
        check("midrst word_cnt", word_cnt, 32'd0);
        check("midrst state", {29'd0, busy, synced, err}, 32'd0);
        check("midrst s_ready", 32'(s_ready), 32'd1);
        @(negedge clk); s_valid = 1'b0;
        @(negedge clk); #2 rst = 1'b1;
        idle(3);

        // Desync command outside SYNCED is plain data.
        cyc(1'b1, 32'h12345678);
        cyc(1'b1, HDR);
        cyc(1'b1, DSY);
        idle(8);
        check("hunt busy", 32'(busy), 32'd1);
        check("hunt synced", 32'(synced), 32'd0);
        check("hunt word_cnt", word_cnt, 32'd3);

        // Desync accepted in the exact cycle the timeout expires.
        d0 = done_seen;
        cyc(1'b1, SYNC);
        cyc(1'b1, HDR);
        idle(T - 1);
        cyc(1'b1, DSY);
        idle(10);
        check("race err", 32'(err), 32'd0);
        check("race done pulses", 32'(done_seen - d0), 32'd1);
        check("race word_cnt", word_cnt, 32'd10);

        // Randomized traffic with protocol words mixed in.
        last = '0;
        for (int n = 0; n < 4000; n++) begin
            logic [31:0] d;
            int r;
            r = int'($urandom % 10);
            case (r)
                0: d = SYNC;
                1: d = HDR;
                2: d = DSY;
                3: d = NOOP;
                default: d = $urandom;
            endcase
            if (last == HDR && ($urandom % 2) == 0) d = DSY;
            cyc(($urandom % 4) != 0, d);
            if (s_valid) last = d;
            if (n == 2000) begin
                cyc(1'b1, SYNC);
                idle(T + 2);
            end
        end
        idle(20);
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        check("trailer drained", 32'(trail.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/icap_write_ctrl.md
Name: icap_write_ctrl

Overview:
- Write-side sequencer between the 128-to-32 AES plaintext FIFO and the ICAPE2 primitive.
- Consumes the decrypted 32-bit bitstream word stream and tracks the configuration packet state: pre-sync, synced, desync.
- Drives ICAP data, CSIB and RDWRB with registered timing and optional per-byte bit swap.
- On a stalled stream, appends a desync plus NOOP trailer so the ICAP is never left mid-packet.

Parameters:
- TIMEOUT_CYCLES, 1024: idle cycles tolerated in SYNCED before abort.
- NOOP_PAD, 4: type-1 NOOP words (0x20000000) emitted after every desync.
- TO_W, $clog2(TIMEOUT_CYCLES+1): timeout counter width.

Ports:
- clk  input  1  system clock (100 MHz).
- rst  input  1  asynchronous, active-low reset.
- s_data  input  32  plaintext bitstream word from FIFO.
- s_valid  input  1  s_data valid.
- s_ready  output  1  word accepted when s_valid && s_ready.
- icap_i  output  32  ICAPE2 I bus.
- icap_csib  output  1  ICAPE2 CSIB, active-low enable.
- icap_rdwrb  output  1  ICAPE2 RDWRB; constant 0 (write only).
- busy  output  1  state != IDLE.
- synced  output  1  high in SYNCED.
- done  output  1  one-cycle pulse when a desync trailer completes.
- err  output  1  sticky timeout flag; cleared only by reset.
- word_cnt  output  32  words driven to ICAP since reset, saturating at 0xFFFFFFFF.

Behaviour:
- Reset (rst=0, async): state IDLE; icap_csib=1; icap_i=0; icap_rdwrb=0; busy, synced, done, err all 0; word_cnt=0; history register=0; timeout counter=0.
- Outputs are registered.
  - An accepted word appears on icap_i with icap_csib=0 in the next cycle (latency 1).
  - icap_csib=1 in any cycle with no word to drive.
- Throughput: one word per cycle.
  - s_ready=1 in IDLE, HUNT and SYNCED.
  - s_ready=0 in ABORT_HDR, ABORT_CMD, PAD and DONE.
- Sync and desync comparisons always use raw s_data, before any bit swap.
- States:
  - IDLE: an accepted word is forwarded. If it equals 0xAA995566, go to SYNCED; otherwise go to HUNT.
  - HUNT: forward every accepted word (dummy and bus-width words included). Go to SYNCED on 0xAA995566. No timeout in this state.
  - SYNCED: forward words; hist <= last accepted word.
    - If hist==0x30008001 and the accepted word is 0x0000000D (DESYNC command), forward it, then go to PAD.
    - The timeout counter increments on each cycle without an accepted word and clears on each accept. At TIMEOUT_CYCLES, set err and go to ABORT_HDR.
  - ABORT_HDR: emit 0x30008001; go to ABORT_CMD.
  - ABORT_CMD: emit 0x0000000D; go to PAD.
  - PAD: emit NOOP_PAD words of 0x20000000, one per cycle; go to DONE.
  - DONE: csib=1; done=1 for this cycle; clear hist; go to IDLE.
- A desync word arriving in the same cycle the timeout expires: the accept wins. The word is forwarded, go to PAD, err stays 0.
- A sync word seen again while in SYNCED is forwarded with no state change.
- word_cnt increments on every cycle with icap_csib=0 (forwarded and generated words alike).
- Reset mid-packet: immediate return to IDLE with csib=1. No trailer is emitted.
- NOOP_PAD=0: PAD goes straight to DONE.

Optional Feature:
- Macro ICAP_BITSWAP_EN.
- Defined: icap_i is bit-reversed within each byte (bit 0<->7, 1<->6, and so on, per byte) on forwarded and generated words. This matches the 7-series ICAP bit ordering for raw .bin data.
- Undefined: icap_i carries words unmodified.
- Compare logic and word_cnt are identical in both builds.

Decomposition:
- Package icap_pkg holds:
  - Constants: SYNC_WORD 0xAA995566, CMD_HDR 0x30008001, DESYNC_CMD 0x0000000D, NOOP_WORD 0x20000000.
  - The state enum typedef.
  - Function bitswap32.
- No sub-module; the timeout counter and FSM fit in one module.

Test Plan:
- Stream FFFFFFFF, 000000BB, 11220044, AA995566, 20000000, 30008001, 0000000D, with s_valid held high → seven ICAP writes one cycle after each accept. synced rises after the 4th accept. Then four 20000000 words, done pulses, word_cnt=11, back to IDLE.
- After sync, drop s_valid for 1024 cycles → err=1. ICAP receives 30008001, 0000000D, then 4× 20000000. done pulses, s_ready low during the trailer.
- Assert rst=0 while synced in mid-stream → same edge: icap_csib=1, state IDLE, word_cnt=0, no trailer words.
- ICAP_BITSWAP_EN build, input AA995566 → icap_i=5599AA66 and synced still asserts.
- Input 0000000D while in HUNT (no preceding 30008001 in SYNCED) → forwarded, no desync, state remains HUNT.
- Desync word accepted in the exact cycle the timeout counter reaches TIMEOUT_CYCLES → normal PAD/done, err=0, no 30008001 trailer.
